// File: rtl/toggle_bank_pkg.sv
// Shared types for the toggle_bank activity monitor.
// The window FSM state is kept here so other activity monitors can reuse it.
package toggle_bank_pkg;

    typedef enum logic {
        WIN_COUNT  = 1'b0,
        WIN_REPORT = 1'b1
    } win_state_t;

endpackage

// File: rtl/toggle_bank_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module bit_popcount #(
    parameter int WIDTH = 8,
    parameter int OUT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [OUT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + OUT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/toggle_bank.sv
// Multi-bit enabled toggle register with running parity, saturating toggle
// counter and a windowed toggle-rate report.
module toggle_bank
    import toggle_bank_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             q_parity,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             cnt_sat,
    output logic             win_valid,
    output logic [CNT_W-1:0] win_cnt
);

    localparam int PC_W = $clog2(WIDTH + 1);
    localparam int WC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WINDOW - 1);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0]  b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W + 1)'(b);
        return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [WC_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    win_state_t       state_q, state_d;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] cnt_sum;
    logic [CNT_W-1:0] acc_sum;
    logic             win_done;

    bit_popcount #(.WIDTH(WIDTH), .OUT_W(PC_W)) u_popcount (
        .bits  (d),
        .count (pc)
    );

    assign cnt_sum = sat_add(cnt_q, pc);
    assign acc_sum = sat_add(acc_q, pc);

    always_comb begin
        q_d       = q_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        acc_d     = acc_q;
        cyc_d     = cyc_q;
        win_cnt_d = win_cnt_q;
        win_done  = 1'b0;
        if (clr) begin
            q_d       = '0;
            cnt_d     = '0;
            sat_d     = 1'b0;
            acc_d     = '0;
            cyc_d     = '0;
            win_cnt_d = '0;
        end else if (load) begin
            q_d = load_val;
        end else if (en) begin
            q_d   = q_q ^ d;
            cnt_d = cnt_sum;
            sat_d = sat_q | (cnt_sum == CNT_MAX);
            // The closing update of a window still contributes its own popcount.
            if (cyc_q == WIN_LAST) begin
                win_cnt_d = acc_sum;
                acc_d     = '0;
                cyc_d     = '0;
                win_done  = 1'b1;
            end else begin
                acc_d = acc_sum;
                cyc_d = cyc_q + WC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q       <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            acc_q     <= '0;
            cyc_q     <= '0;
            win_cnt_q <= '0;
        end else begin
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            acc_q     <= acc_d;
            cyc_q     <= cyc_d;
            win_cnt_q <= win_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WIN_COUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // clr suppresses win_done, so a clear always returns to counting.
    always_comb begin
        state_d = WIN_COUNT;
        if (win_done) begin
            state_d = WIN_REPORT;
        end
    end

    always_comb begin
        win_valid = (state_q == WIN_REPORT);
    end

    assign q          = q_q;
    assign q_parity   = ^q_q;
    assign toggle_cnt = cnt_q;
    assign cnt_sat    = sat_q;
    assign win_cnt    = win_cnt_q;

endmodule

// File: tb/tb_toggle_bank.sv
// Directed bench for toggle_bank: a WIDTH=4 instance and a WIDTH=1 instance.
module tb_toggle_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, clr, load;
    logic [3:0] d, load_val;
    logic [3:0] q;
    logic       q_parity, cnt_sat, win_valid;
    logic [7:0] toggle_cnt, win_cnt;

    logic       en1;
    logic [0:0] d1, q1;
    logic       q1_parity, cnt_sat1, win_valid1;
    logic [7:0] toggle_cnt1, win_cnt1;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    toggle_bank #(.WIDTH(4), .CNT_W(8), .WINDOW(4)) dut (
        .clk(clk), .rst(rst), .en(en), .d(d), .clr(clr), .load(load),
        .load_val(load_val), .q(q), .q_parity(q_parity), .toggle_cnt(toggle_cnt),
        .cnt_sat(cnt_sat), .win_valid(win_valid), .win_cnt(win_cnt)
    );

    toggle_bank #(.WIDTH(1), .CNT_W(8), .WINDOW(4)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .d(d1), .clr(1'b0), .load(1'b0),
        .load_val(1'b0), .q(q1), .q_parity(q1_parity), .toggle_cnt(toggle_cnt1),
        .cnt_sat(cnt_sat1), .win_valid(win_valid1), .win_cnt(win_cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] stream;
        logic        run_xor;

        rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; d = '0; load_val = '0;
        en1 = 1'b0; d1 = '0;
        step();
        step();
        check("rst_q", q, 4'h0);
        check("rst_cnt", toggle_cnt, 8'd0);
        rst = 1'b0;

        // Basic toggling from q=0
        en = 1'b1; d = 4'b0011; step();
        check("t2_q0", q, 4'b0011); check("t2_cnt0", toggle_cnt, 8'd2); check("t2_par0", q_parity, 1'b0);
        d = 4'b0101; step();
        check("t2_q1", q, 4'b0110); check("t2_cnt1", toggle_cnt, 8'd4); check("t2_par1", q_parity, 1'b0);
        d = 4'b1111; step();
        check("t2_q2", q, 4'b1001); check("t2_cnt2", toggle_cnt, 8'd8); check("t2_par2", q_parity, 1'b0);
        check("t2_novalid", win_valid, 1'b0);
        d = 4'b0001; step();
        check("t2_q3", q, 4'b1000); check("t2_par3", q_parity, 1'b1);
        check("t2_valid", win_valid, 1'b1); check("t2_wcnt", win_cnt, 8'd9);

        // Asynchronous reset between edges, while win_valid is high
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t1_q", q, 4'h0); check("t1_cnt", toggle_cnt, 8'd0); check("t1_sat", cnt_sat, 1'b0);
        check("t1_valid", win_valid, 1'b0); check("t1_wcnt", win_cnt, 8'd0);
        rst = 1'b0;

        // Window counts only enabled cycles
        d = 4'b0001;
        en = 1'b1; step(); check("t3_v1", win_valid, 1'b0);
        en = 1'b0; d = 4'b1111; step(); check("t3_hold_q", q, 4'b0001); check("t3_hold_cnt", toggle_cnt, 8'd1);
        d = 4'b0001; step();
        en = 1'b1; step(); check("t3_v2", win_valid, 1'b0);
        en = 1'b0; step();
        en = 1'b1; step(); check("t3_v3", win_valid, 1'b0);
        en = 1'b0; step(); check("t3_gap", win_valid, 1'b0);
        en = 1'b1; step();
        check("t3_valid", win_valid, 1'b1); check("t3_wcnt", win_cnt, 8'd4); check("t3_q", q, 4'b0000);
        en = 1'b0; step();
        check("t3_pulse_end", win_valid, 1'b0); check("t3_wcnt_held", win_cnt, 8'd4);

        // Counter saturation coinciding with a window completion
        clr = 1'b1; step(); clr = 1'b0;
        check("t4_clr_cnt", toggle_cnt, 8'd0); check("t4_clr_wcnt", win_cnt, 8'd0);
        en = 1'b1; d = 4'b1111;
        for (int i = 0; i < 63; i++) step();
        check("t4_cnt63", toggle_cnt, 8'd252); check("t4_sat63", cnt_sat, 1'b0);
        step();
        check("t4_cnt64", toggle_cnt, 8'd255); check("t4_sat64", cnt_sat, 1'b1);
        check("t4_valid64", win_valid, 1'b1); check("t4_wcnt64", win_cnt, 8'd16);
        step();
        check("t4_cnt65", toggle_cnt, 8'd255); check("t4_sat65", cnt_sat, 1'b1);
        check("t4_valid65", win_valid, 1'b0); check("t4_q65", q, 4'b1111);
        en = 1'b0; clr = 1'b1; step(); clr = 1'b0;
        check("t4_clr_cnt2", toggle_cnt, 8'd0); check("t4_clr_sat", cnt_sat, 1'b0);
        check("t4_clr_q", q, 4'h0);

        // Priority clr > load > en
        en = 1'b1; d = 4'b0011; step();
        check("t5_pre_q", q, 4'b0011);
        clr = 1'b1; load = 1'b1; load_val = 4'b1010; d = 4'b1111; step();
        check("t5_clr_q", q, 4'b0000); check("t5_clr_cnt", toggle_cnt, 8'd0);
        clr = 1'b0; load = 1'b0; d = 4'b0011; step();
        check("t5_en_cnt", toggle_cnt, 8'd2);
        load = 1'b1; d = 4'b1111; step(); load = 1'b0;
        check("t5_load_q", q, 4'b1010); check("t5_load_cnt", toggle_cnt, 8'd2);
        d = 4'b0001;
        step(); step();
        check("t5_win_not_advanced", win_valid, 1'b0); check("t5_q2", q, 4'b1010);
        step();
        check("t5_valid", win_valid, 1'b1); check("t5_wcnt", win_cnt, 8'd5);
        check("t5_cnt", toggle_cnt, 8'd5); check("t5_q3", q, 4'b1011);
        en = 1'b0;

        // WIDTH=1 instance against a running XOR of the stream
        stream  = 12'b1011_0010_1101;
        run_xor = 1'b0;
        en1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            d1 = stream[i];
            run_xor = run_xor ^ stream[i];
            step();
            check($sformatf("t6_q%0d", i), q1, run_xor);
        end
        check("t6_cnt", toggle_cnt1, 8'd7);
        check("t6_par", q1_parity, run_xor);
        en1 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
